// File: rtl/wb_sram_sword_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_sram_sword_ctrl_if
// Description : Wishbone B4 slave-side bus bundle for the SRAM controller.
//               The master drives the request fields. The slave returns
//               the read data and the acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_sram_sword_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [29:0] wbs_addr_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_data_i;
    logic [31:0] wbs_data_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_cti_i,
               wbs_bte_i, wbs_sel_i, wbs_data_i,
        input  wbs_data_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_cti_i,
               wbs_bte_i, wbs_sel_i, wbs_data_i,
        output wbs_data_o, wbs_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_sram_sword_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_sram_sword_ctrl
// Description : Multi-cycle Wishbone slave for a 48-bit asynchronous SRAM.
//               It supports programmable read and write wait states. A
//               partial byte-select write is done as a read-modify-write.
//               Incrementing bursts keep chip-enable low between beats.
//               Every SRAM pin output and every bus output is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_sram_sword_ctrl #(
    parameter int unsigned              ADDR_BITS  = 22,
    parameter logic [31-ADDR_BITS:0]    HIGH_ADDR  = '0,
    parameter int unsigned              DATA_BITS  = 48,
    parameter int unsigned              READ_WAIT  = 1,
    parameter int unsigned              WRITE_WAIT = 1
) (
    input  logic                    clk,
    input  logic                    rst,        // asynchronous, active low
    wb_sram_sword_ctrl_if.slave     wb,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic [ADDR_BITS-3:0]    sram_addr,
    input  logic [DATA_BITS-1:0]    sram_din,
    output logic [DATA_BITS-1:0]    sram_dout
);

    localparam logic [3:0] c_read_wait  = 4'(READ_WAIT);
    localparam logic [3:0] c_write_wait = 4'(WRITE_WAIT);
    localparam logic [2:0] c_cti_incr   = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RMW   = 3'd2,
        S_TURN  = 3'd3,
        S_WRITE = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    state_t                 r_state, w_state;
    logic [3:0]             r_cnt, w_cnt;
    logic                   r_burst, w_burst;
    logic                   r_ce_n, w_ce_n;
    logic                   r_oe_n, w_oe_n;
    logic                   r_we_n, w_we_n;
    logic [ADDR_BITS-3:0]   r_addr, w_addr;
    logic [DATA_BITS-1:0]   r_dout, w_dout;
    logic [31:0]            r_data_o, w_data_o;
    logic                   r_ack, w_ack;

    logic                   w_cs;
    logic [31:0]            w_merge;
    logic                   w_unused;

    // The upper SRAM data bits and the burst-type field carry no meaning here.
    assign w_unused = ^{wb.wbs_bte_i, sram_din[DATA_BITS-1:32]};

    assign w_cs = wb.wbs_cyc_i & wb.wbs_stb_i &
                  (wb.wbs_addr_i[29:ADDR_BITS-2] == HIGH_ADDR);

    // This is the read-modify-write merge. The old word comes from the pins,
    // and each selected byte is replaced with the new write data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merge[8*gi +: 8] = wb.wbs_sel_i[gi] ? wb.wbs_data_i[8*gi +: 8]
                                                     : sram_din[8*gi +: 8];
    end

    // Next-state logic and next values of all registered outputs.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_burst  = r_burst;
        w_ce_n   = r_ce_n;
        w_oe_n   = r_oe_n;
        w_we_n   = r_we_n;
        w_addr   = r_addr;
        w_dout   = r_dout;
        w_data_o = r_data_o;
        w_ack    = 1'b0;

        if (r_state != S_IDLE && !wb.wbs_cyc_i) begin
            // The master abandoned the cycle. Release the SRAM without an ack.
            w_ce_n   = 1'b1;
            w_oe_n   = 1'b1;
            w_we_n   = 1'b1;
            w_data_o = '0;
            w_cnt    = '0;
            w_state  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs) begin
                        w_addr  = wb.wbs_addr_i[ADDR_BITS-3:0];
                        w_burst = (wb.wbs_cti_i == c_cti_incr);
                        if (!wb.wbs_we_i) begin
                            w_ce_n  = 1'b0;
                            w_oe_n  = 1'b0;
                            w_cnt   = c_read_wait;
                            w_state = S_READ;
                        end else if (wb.wbs_sel_i == 4'hF) begin
                            w_dout  = {{(DATA_BITS-32){1'b0}}, wb.wbs_data_i};
                            w_ce_n  = 1'b0;
                            w_we_n  = 1'b0;
                            w_cnt   = c_write_wait;
                            w_state = S_WRITE;
                        end else if (wb.wbs_sel_i != 4'h0) begin
                            w_ce_n  = 1'b0;
                            w_oe_n  = 1'b0;
                            w_cnt   = c_read_wait;
                            w_state = S_RMW;
                        end else begin
                            // A write with no byte selected needs no SRAM access.
                            w_ack   = 1'b1;
                            w_state = S_ACK;
                        end
                    end else if (!wb.wbs_cyc_i) begin
                        // When a held burst ends between beats, chip-enable is released here.
                        w_ce_n = 1'b1;
                    end
                end
                S_READ: begin
                    if (r_cnt != 4'd0) begin
                        w_cnt = r_cnt - 4'd1;
                    end else begin
                        w_data_o = sram_din[31:0];
                        w_ack    = 1'b1;
                        w_oe_n   = 1'b1;
                        w_state  = S_ACK;
                    end
                end
                S_RMW: begin
                    if (r_cnt != 4'd0) begin
                        w_cnt = r_cnt - 4'd1;
                    end else begin
                        w_dout  = {{(DATA_BITS-32){1'b0}}, w_merge};
                        w_oe_n  = 1'b1;
                        w_state = S_TURN;
                    end
                end
                S_TURN: begin
                    // There is one dead cycle here. The SRAM stops driving the
                    // bus before we_n falls.
                    w_we_n  = 1'b0;
                    w_cnt   = c_write_wait;
                    w_state = S_WRITE;
                end
                S_WRITE: begin
                    if (r_cnt != 4'd0) begin
                        w_cnt = r_cnt - 4'd1;
                    end else begin
                        w_we_n  = 1'b1;
                        w_ack   = 1'b1;
                        w_state = S_ACK;
                    end
                end
                S_ACK: begin
                    // The master still holds stb here, so cs is not looked at.
                    w_data_o = '0;
                    if (!(r_burst && wb.wbs_cyc_i)) begin
                        w_ce_n = 1'b1;
                    end
                    w_state = S_IDLE;
                end
                default: begin
                    w_ce_n  = 1'b1;
                    w_oe_n  = 1'b1;
                    w_we_n  = 1'b1;
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers, with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_burst  <= 1'b0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_addr   <= '0;
            r_dout   <= '0;
            r_data_o <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_burst  <= w_burst;
            r_ce_n   <= w_ce_n;
            r_oe_n   <= w_oe_n;
            r_we_n   <= w_we_n;
            r_addr   <= w_addr;
            r_dout   <= w_dout;
            r_data_o <= w_data_o;
            r_ack    <= w_ack;
        end
    end

    assign sram_ce_n     = r_ce_n;
    assign sram_oe_n     = r_oe_n;
    assign sram_we_n     = r_we_n;
    assign sram_addr     = r_addr;
    assign sram_dout     = r_dout;
    assign wb.wbs_data_o = r_data_o;
    assign wb.wbs_ack_o  = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_sword_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_sram_sword_ctrl
// Description : Self-checking bench for wb_sram_sword_ctrl. It contains an
//               asynchronous SRAM model, a table of directed transfers, hand
//               sequences for bursts, decode and reset, and a randomized
//               phase checked against a word-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_sram_sword_ctrl;

    localparam int R  = 1;
    localparam int W  = 2;
    localparam int AB = 22;
    localparam int DB = 48;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sram_ce_n, sram_oe_n, sram_we_n;
    logic [AB-3:0]  sram_addr;
    logic [DB-1:0]  sram_din, sram_dout;

    wb_sram_sword_ctrl_if wb();

    wb_sram_sword_ctrl #(
        .ADDR_BITS (AB),
        .HIGH_ADDR (10'h000),
        .DATA_BITS (DB),
        .READ_WAIT (R),
        .WRITE_WAIT(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (wb),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model. It drives data while ce and oe are both low,
    // and it stores the word on the rising edge of we_n.
    logic [DB-1:0] mem [0:1023];
    assign sram_din = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) ? mem[sram_addr[9:0]]
                                                                 : 48'hBAD0_BAD0_BAD0;
    always @(posedge sram_we_n)
        if (rst && sram_ce_n === 1'b0) mem[sram_addr[9:0]] <= sram_dout;

    // The pin monitor samples on the falling edge, away from the active edge.
    int n_oe = 0, n_we = 0, n_ce_hi = 0, n_ce_lo = 0, n_ack = 0;
    int n_both = 0, n_hi_addr = 0;
    logic [2:0] trace [$];
    always @(negedge clk) begin
        if (sram_oe_n === 1'b0) n_oe <= n_oe + 1;
        if (sram_we_n === 1'b0) n_we <= n_we + 1;
        if (sram_oe_n === 1'b0 && sram_we_n === 1'b0) n_both <= n_both + 1;
        if (sram_ce_n === 1'b1) n_ce_hi <= n_ce_hi + 1;
        else n_ce_lo <= n_ce_lo + 1;
        if (wb.wbs_ack_o === 1'b1) n_ack <= n_ack + 1;
        if (sram_addr[AB-3:10] != '0) n_hi_addr <= n_hi_addr + 1;
        trace.push_back({sram_ce_n, sram_oe_n, sram_we_n});
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic clear_mon();
        n_oe = 0; n_we = 0; n_ce_hi = 0; n_ce_lo = 0; n_ack = 0;
        trace.delete();
    endtask

    task automatic wb_idle();
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_addr_i = '0; wb.wbs_cti_i = '0; wb.wbs_bte_i = '0;
        wb.wbs_sel_i = '0; wb.wbs_data_i = '0;
    endtask

    // This returns the number of all-high cycles between the last oe_n-low
    // cycle and the first we_n-low cycle.
    function automatic int turn_gap();
        int last_oe = -1;
        int first_we = -1;
        foreach (trace[i]) begin
            if (trace[i][1] == 1'b0) last_oe = i;
            if (trace[i][0] == 1'b0 && first_we < 0) first_we = i;
        end
        if (last_oe < 0 || first_we < 0) return -1;
        return first_we - last_oe - 1;
    endfunction

    // This drives one beat just after a rising edge, so the next rising edge is E0.
    // lat is k when ack is first seen after edge E0+k, and it is -1 on timeout.
    // The task returns just after the edge that ends the ACK cycle.
    task automatic wb_beat(input string nm, input logic we, input logic [29:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input logic [2:0] cti, output logic [31:0] rdat, output int lat);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_addr_i = adr; wb.wbs_sel_i = sel; wb.wbs_data_i = dat;
        wb.wbs_cti_i = cti; wb.wbs_bte_i = 2'($urandom);
        clear_mon();
        lat = -1;
        rdat = '0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o === 1'b1) begin
                lat = k;
                rdat = wb.wbs_data_o;
                break;
            end
        end
        @(posedge clk); #1;
        if (lat >= 0) chk({nm, "_ack_clear"}, {wb.wbs_ack_o, wb.wbs_data_o}, 33'h0);
    endtask

    task automatic wb_single(input string nm, input logic we, input logic [29:0] adr,
                             input logic [3:0] sel, input logic [31:0] dat,
                             output logic [31:0] rdat, output int lat);
        wb_beat(nm, we, adr, sel, dat, 3'b000, rdat, lat);
        wb_idle();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_oe;
        int          exp_we;
        bit          chk_turn;
    } vec_t;

    vec_t          tbl [11];
    logic [31:0]   ref_mem [0:255];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] rd;
        int          lat, sum_ce_hi, sum_ack, mism;

        // Directed vectors: read, full write, partial write and sel=0 write.
        tbl[0]  = '{1'b0, 30'h040, 4'hF, 32'h0,        32'hDEADBEEF, R+1,     R+1, 0,   1'b0};
        tbl[1]  = '{1'b1, 30'h010, 4'hF, 32'hCAFEF00D, 32'h0,        W+1,     0,   W+1, 1'b0};
        tbl[2]  = '{1'b0, 30'h010, 4'h3, 32'h0,        32'hCAFEF00D, R+1,     R+1, 0,   1'b0};
        tbl[3]  = '{1'b1, 30'h020, 4'h5, 32'hAABBCCDD, 32'h0,        R+W+3,   R+1, W+1, 1'b1};
        tbl[4]  = '{1'b0, 30'h020, 4'hF, 32'h0,        32'h11BB33DD, R+1,     R+1, 0,   1'b0};
        tbl[5]  = '{1'b1, 30'h020, 4'h0, 32'hFFFFFFFF, 32'h0,        0,       0,   0,   1'b0};
        tbl[6]  = '{1'b0, 30'h020, 4'hF, 32'h0,        32'h11BB33DD, R+1,     R+1, 0,   1'b0};
        tbl[7]  = '{1'b1, 30'h020, 4'h8, 32'h99000000, 32'h0,        R+W+3,   R+1, W+1, 1'b1};
        tbl[8]  = '{1'b0, 30'h020, 4'hF, 32'h0,        32'h99BB33DD, R+1,     R+1, 0,   1'b0};
        tbl[9]  = '{1'b1, 30'h021, 4'hE, 32'h01020304, 32'h0,        R+W+3,   R+1, W+1, 1'b1};
        tbl[10] = '{1'b0, 30'h021, 4'hF, 32'h0,        32'h01020388, R+1,     R+1, 0,   1'b0};

        for (int i = 0; i < 1024; i++) mem[i] = 48'h0;
        mem[10'h040] = 48'h1234_DEADBEEF;
        mem[10'h020] = 48'h0000_11223344;
        mem[10'h021] = 48'hFFFF_55667788;
        for (int i = 0; i < 4; i++) mem[10'h030 + i] = 48'h7777_B0000000 | 48'(i * 32'h0101_0101);

        // This checks the values held during reset.
        wb_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes_ack", {sram_ce_n, sram_oe_n, sram_we_n, wb.wbs_ack_o}, 4'b1110);
        chk("reset_addr_data", {sram_addr, wb.wbs_data_o}, 52'h0);
        chk("reset_dout", sram_dout, 48'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven directed transfers.
        for (int i = 0; i < 11; i++) begin
            wb_single($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd, lat);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_oe_cycles", i), n_oe, tbl[i].exp_oe);
            chk($sformatf("vec%0d_we_cycles", i), n_we, tbl[i].exp_we);
            if (tbl[i].chk_turn) chk($sformatf("vec%0d_turn", i), turn_gap(), 1);
        end
        chk("mem_full_write", mem[10'h010], 48'h0000_CAFEF00D);
        chk("mem_partial_write", mem[10'h020], 48'h0000_99BB33DD);
        chk("mem_partial_upper", mem[10'h021], 48'h0000_01020388);

        // Four-beat incrementing burst read. Chip-enable must stay low between beats.
        sum_ce_hi = 0;
        sum_ack = 0;
        for (int b = 0; b < 4; b++) begin
            wb_beat($sformatf("burst%0d", b), 1'b0, 30'h030 + 30'(b), 4'hF, 32'h0,
                    (b == 3) ? 3'b111 : 3'b010, rd, lat);
            sum_ce_hi += n_ce_hi;
            sum_ack += n_ack;
            chk($sformatf("burst%0d_latency", b), lat, R+1);
            chk($sformatf("burst%0d_rdata", b), rd, 32'hB0000000 | (b * 32'h0101_0101));
        end
        chk("burst_ce_high_cycles", sum_ce_hi, 1);
        chk("burst_ack_count", sum_ack, 4);
        chk("burst_ce_release", sram_ce_n, 1'b1);
        wb_idle();
        @(posedge clk); #1;

        // An address outside the selected window must never strobe or ack.
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_addr_i = 30'h0010_0040; wb.wbs_sel_i = 4'hF;
        clear_mon();
        repeat (50) @(posedge clk);
        #1;
        chk("unsel_ack", n_ack, 0);
        chk("unsel_strobes", n_ce_lo + n_oe + n_we, 0);
        wb_idle();
        @(posedge clk); #1;

        // Reset arrives in the middle of a write, while cnt=1.
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
        wb.wbs_addr_i = 30'h050; wb.wbs_sel_i = 4'hF; wb.wbs_data_i = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midwrite_we_low", {sram_ce_n, sram_we_n}, 2'b00);
        rst = 1'b0;
        #1;
        chk("async_rst_strobes_ack", {sram_ce_n, sram_oe_n, sram_we_n, wb.wbs_ack_o}, 4'b1110);
        chk("async_rst_addr", sram_addr, 20'h0);
        chk("async_rst_dout", sram_dout, 48'h0);
        chk("async_rst_data_o", wb.wbs_data_o, 32'h0);
        wb_idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        wb_single("post_rst_read", 1'b0, 30'h040, 4'hF, 32'h0, rd, lat);
        chk("post_rst_latency", lat, R+1);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);

        // Randomized phase, checked against the word-level reference memory.
        for (int i = 128; i < 192; i++) begin
            ref_mem[i] = $urandom;
            mem[i] = {16'h5A5A, ref_mem[i]};
        end
        for (int t = 0; t < 80; t++) begin
            int          op, a, exp_lat;
            logic [31:0] d, exp_rd, word;
            logic [3:0]  sel;
            op = $urandom_range(0, 3);
            a = 128 + $urandom_range(0, 63);
            d = $urandom;
            exp_rd = '0;
            case (op)
                0: begin sel = 4'($urandom); exp_rd = ref_mem[a]; exp_lat = R + 1; end
                1: begin sel = 4'hF; ref_mem[a] = d; exp_lat = W + 1; end
                2: begin
                    sel = 4'($urandom_range(1, 14));
                    word = ref_mem[a];
                    for (int b = 0; b < 4; b++) if (sel[b]) word[8*b +: 8] = d[8*b +: 8];
                    ref_mem[a] = word;
                    exp_lat = R + W + 3;
                end
                default: begin sel = 4'h0; exp_lat = 0; end
            endcase
            wb_single($sformatf("rnd%0d", t), op != 0, 30'(a), sel, d, rd, lat);
            chk($sformatf("rnd%0d_latency", t), lat, exp_lat);
            chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
        end
        mism = 0;
        for (int i = 128; i < 192; i++) if (mem[i][31:0] !== ref_mem[i]) mism++;
        chk("rand_mem_contents", mism, 0);
        chk("oe_we_overlap", n_both, 0);
        chk("addr_in_range", n_hi_addr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
